// File: rtl/ecc_sed_encoder_pipe.sv
// Single-error-detect encoder: appends a parity MSB and buffers codewords in a 2-entry skid FIFO.
// Optional error injection is enabled with the ECC_SED_ERR_INJ_EN macro.
module ecc_sed_encoder_pipe #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          data_valid,
  output logic                          data_ready,
  input  logic [DATA_WIDTH-1:0]         data,
`ifdef ECC_SED_ERR_INJ_EN
  input  logic                          inj_req,
  input  logic [$clog2(DATA_WIDTH+1)-1:0] inj_pos,
`endif
  output logic                          enc_valid,
  input  logic                          enc_ready,
  output logic [DATA_WIDTH:0]           enc_codeword,
  output logic [CNT_WIDTH-1:0]          enc_count
);

  localparam int unsigned CwWidth = DATA_WIDTH + 1;

  logic [CwWidth-1:0]   mem_q [2];
  logic                 rd_ptr_q, wr_ptr_q;
  logic [1:0]           occ_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  logic                 push, pop, parity;
  logic [CwWidth-1:0]   flip_mask, cw_new;

  // Ready depends only on reset and occupancy, never on the handshake inputs.
  assign data_ready   = rst && (occ_q != 2'd2);
  assign enc_valid    = (occ_q != 2'd0);
  assign enc_codeword = mem_q[rd_ptr_q];
  assign enc_count    = cnt_q;

  assign push = data_valid && data_ready;
  assign pop  = enc_valid && enc_ready;

  always_comb begin
    parity = (PARITY_ODD != 0) ? ~^data : ^data;
    flip_mask = '0;
`ifdef ECC_SED_ERR_INJ_EN
    // Out-of-range positions match no bit, so they leave the word unaltered.
    for (int i = 0; i < int'(CwWidth); i++) begin
      if (inj_req && (int'(inj_pos) == i)) flip_mask[i] = 1'b1;
    end
`endif
    cw_new = {parity, data} ^ flip_mask;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= cw_new;
        wr_ptr_q        <= ~wr_ptr_q;
        if (cnt_q != {CNT_WIDTH{1'b1}}) cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_sed_encoder_pipe.sv
// Scoreboard bench: an even/16-bit and an odd/4-bit encoder share stimulus; a queue model
// predicts codewords, occupancy-derived handshakes and saturating counts.
module tb_ecc_sed_encoder_pipe;
  localparam int unsigned DW = 12;
  localparam int unsigned PW = $clog2(DW + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          data_valid = 1'b0;
  logic          enc_ready = 1'b0;
  logic [DW-1:0] data = '0;
`ifdef ECC_SED_ERR_INJ_EN
  logic          inj_req = 1'b0;
  logic [PW-1:0] inj_pos = '0;
`endif

  logic          rdy_e, val_e, rdy_o, val_o;
  logic [DW:0]   cw_e, cw_o;
  logic [15:0]   cnt_e;
  logic [3:0]    cnt_o;

  int passed = 0;
  int total  = 0;
  logic [DW:0] q_e[$];
  logic [DW:0] q_o[$];
  int exp_cnt_e = 0;
  int exp_cnt_o = 0;

  always #5 clk = ~clk;

  ecc_sed_encoder_pipe #(.DATA_WIDTH(DW), .PARITY_ODD(0), .CNT_WIDTH(16)) u_even (
    .clk(clk), .rst(rst), .data_valid(data_valid), .data_ready(rdy_e), .data(data),
`ifdef ECC_SED_ERR_INJ_EN
    .inj_req(inj_req), .inj_pos(inj_pos),
`endif
    .enc_valid(val_e), .enc_ready(enc_ready), .enc_codeword(cw_e), .enc_count(cnt_e)
  );

  ecc_sed_encoder_pipe #(.DATA_WIDTH(DW), .PARITY_ODD(1), .CNT_WIDTH(4)) u_odd (
    .clk(clk), .rst(rst), .data_valid(data_valid), .data_ready(rdy_o), .data(data),
`ifdef ECC_SED_ERR_INJ_EN
    .inj_req(inj_req), .inj_pos(inj_pos),
`endif
    .enc_valid(val_o), .enc_ready(enc_ready), .enc_codeword(cw_o), .enc_count(cnt_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Codeword from the definition: popcount parity, optional single-bit flip.
  function automatic logic [DW:0] model_cw(input logic [DW-1:0] d, input bit odd,
                                           input bit inj, input int pos);
    logic [DW:0] cw;
    bit p;
    p  = ($countones(d) % 2) == 1;
    if (odd) p = !p;
    cw = {p, d};
    if (inj && pos <= int'(DW)) cw[pos] = ~cw[pos];
    return cw;
  endfunction

  always @(negedge clk) begin
    bit acc, inj;
    int pos;
    if (!rst) begin
      q_e.delete();
      q_o.delete();
      exp_cnt_e = 0;
      exp_cnt_o = 0;
      check("rst_ready", rdy_e, 0);
      check("rst_valid", val_e, 0);
      check("rst_codeword", cw_e, 0);
      check("rst_count", cnt_e, 0);
      check("rst_count_odd", cnt_o, 0);
    end else begin
      check("ready", rdy_e, q_e.size() != 2);
      check("ready_odd", rdy_o, q_o.size() != 2);
      check("valid", val_e, q_e.size() != 0);
      check("valid_odd", val_o, q_o.size() != 0);
      if (q_e.size() != 0) check("codeword", cw_e, q_e[0]);
      if (q_o.size() != 0) check("codeword_odd", cw_o, q_o[0]);
      check("count", cnt_e, exp_cnt_e);
      check("count_odd", cnt_o, exp_cnt_o);
`ifdef ECC_SED_ERR_INJ_EN
      inj = inj_req;
      pos = int'(inj_pos);
`else
      inj = 1'b0;
      pos = 0;
`endif
      acc = data_valid && (q_e.size() != 2);
      if (enc_ready && q_e.size() != 0) begin
        void'(q_e.pop_front());
        void'(q_o.pop_front());
      end
      if (acc) begin
        q_e.push_back(model_cw(data, 1'b0, inj, pos));
        q_o.push_back(model_cw(data, 1'b1, inj, pos));
        if (exp_cnt_e < 65535) exp_cnt_e++;
        if (exp_cnt_o < 15) exp_cnt_o++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offer one word until accepted, bounded by a cycle budget.
  task automatic send(input logic [DW-1:0] d);
    bit done;
    done = 1'b0;
    data_valid = 1'b1;
    data = d;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = rdy_e;
      cyc();
    end
    check("send_accepted", done, 1);
    data_valid = 1'b0;
    data = 'x;
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (3) cyc();
    rst = 1'b1;

    enc_ready = 1'b1;
    send(12'h001);
    send(12'h003);
    send(12'hFFF);
    send(12'h000);
    repeat (2) cyc();

    // Backpressure: third word waits until the consumer drains.
    enc_ready = 1'b0;
    fork
      begin
        send(12'h0A1);
        send(12'h0A2);
        send(12'h0A3);
      end
      begin
        repeat (6) cyc();
        enc_ready = 1'b1;
      end
    join
    repeat (3) cyc();

    for (int n = 0; n < 400; n++) begin
      data_valid = ($urandom % 3) != 0;
      data = DW'($urandom);
      if (!data_valid) data = 'x;
      enc_ready = ($urandom % 4) != 0;
`ifdef ECC_SED_ERR_INJ_EN
      inj_req = ($urandom % 4) == 0;
      inj_pos = PW'($urandom);
`endif
      cyc();
    end
    data_valid = 1'b0;
    data = 'x;
`ifdef ECC_SED_ERR_INJ_EN
    inj_req = 1'b0;
`endif
    enc_ready = 1'b1;
    repeat (3) cyc();

    // Asynchronous reset with the buffer full.
    enc_ready = 1'b0;
    send(12'h5A5);
    send(12'h123);
    cyc();
    rst = 1'b0;
    #1;
    check("async_rst_valid", val_e, 0);
    check("async_rst_codeword", cw_e, 0);
    check("async_rst_count", cnt_e, 0);
    check("async_rst_ready", rdy_e, 0);
    repeat (2) cyc();
    rst = 1'b1;
    enc_ready = 1'b1;
    repeat (2) cyc();

`ifdef ECC_SED_ERR_INJ_EN
    inj_req = 1'b1;
    inj_pos = PW'(12);
    send(12'h000);
    inj_pos = PW'(0);
    send(12'h000);
    inj_pos = PW'(13);
    send(12'h000);
    inj_req = 1'b0;
    repeat (2) cyc();
`endif

    for (int n = 0; n < 30; n++) begin
      send(DW'($urandom));
    end
    repeat (4) cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
